// File: rtl/pong_game_ctrl.sv
// Pong match controller: serve timing, wall and paddle bounces,
// miss scoring and match-over handling. All outputs are registered.
module pong_game_ctrl #(
  parameter int WALL_TOP     = 0,
  parameter int WALL_BOT     = 479,
  parameter int PAD_LX       = 8,
  parameter int PAD_RX       = 631,
  parameter int PAD_H        = 48,
  parameter int MISS_L       = 2,
  parameter int MISS_R       = 637,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve_btn,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic       ball_reset,
  output logic       ball_run,
  output logic       serve_dir,
  output logic       bounce_x,
  output logic       bounce_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } st_t;

  localparam logic [9:0]  TOP_Y   = 10'(WALL_TOP);
  localparam logic [9:0]  BOT_Y   = 10'(WALL_BOT);
  localparam logic [9:0]  LX      = 10'(PAD_LX);
  localparam logic [9:0]  RX      = 10'(PAD_RX);
  localparam logic [9:0]  ML      = 10'(MISS_L);
  localparam logic [9:0]  MR      = 10'(MISS_R);
  localparam logic [10:0] PH_M1   = 11'(PAD_H - 1);
  localparam logic [3:0]  WIN     = 4'(WIN_SCORE);
  localparam logic [5:0]  SRV_END = 6'(SERVE_FRAMES - 1);
  localparam logic [5:0]  PNT_END = 6'(POINT_FRAMES - 1);

  st_t        st_q, st_d;
  logic       btn_q, armed_q, press;
  logic [5:0] cnt_q, cnt_d;
  logic       miss_l, miss_r, wall, hit_l, hit_r, win;
  logic [10:0] y11, pl11, pr11;

  logic       ball_reset_d, ball_run_d, serve_dir_d;
  logic       bounce_x_d, bounce_y_d, game_over_d;
  logic [3:0] score_l_d, score_r_d;

  // A button held through reset stays disarmed until it is seen low.
  assign press = serve_btn & ~btn_q & armed_q;

  assign y11  = {1'b0, ball_y};
  assign pl11 = {1'b0, paddle_l_y};
  assign pr11 = {1'b0, paddle_r_y};

  assign miss_l = ball_x <= ML;
  assign miss_r = ball_x >= MR;
  assign wall   = (ball_y <= TOP_Y) || (ball_y >= BOT_Y);
  assign hit_l  = (ball_x <= LX) && (ball_x > ML) &&
                  (y11 >= pl11) && (y11 <= pl11 + PH_M1);
  assign hit_r  = (ball_x >= RX) && (ball_x < MR) &&
                  (y11 >= pr11) && (y11 <= pr11 + PH_M1);
  assign win    = (score_l == WIN) || (score_r == WIN);

  assign state = st_q;

  // State register plus serve button edge detector
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= IDLE;
      btn_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      btn_q   <= serve_btn;
      armed_q <= armed_q | ~serve_btn;
    end
  end

  // Next-state selection
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:  if (press) st_d = SERVE;
      SERVE: if (frame_tick && cnt_q == SRV_END) st_d = PLAY;
      PLAY:  if (frame_tick && (miss_l || miss_r)) st_d = POINT;
      POINT: if (frame_tick && cnt_q == PNT_END)
               st_d = win ? OVER : SERVE;
      OVER:  if (press) st_d = SERVE;
      default: st_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and frame counter
  always_comb begin
    ball_reset_d = (st_d == SERVE) && (st_q != SERVE);
    ball_run_d   = st_d == PLAY;
    game_over_d  = st_d == OVER;
    bounce_x_d   = 1'b0;
    bounce_y_d   = 1'b0;
    score_l_d    = score_l;
    score_r_d    = score_r;
    serve_dir_d  = serve_dir;
    cnt_d        = cnt_q;
    if (st_q == PLAY && frame_tick) begin
      if (miss_l) begin
        if (score_r < WIN) score_r_d = score_r + 4'd1;
        serve_dir_d = 1'b1;
      end else if (miss_r) begin
        if (score_l < WIN) score_l_d = score_l + 4'd1;
        serve_dir_d = 1'b0;
      end else begin
        bounce_x_d = hit_l | hit_r;
        bounce_y_d = wall;
      end
    end
    if (st_q == OVER && press) begin
      score_l_d   = 4'd0;
      score_r_d   = 4'd0;
      serve_dir_d = 1'b0;
    end
    if (st_d != st_q)
      cnt_d = 6'd0;
    else if (frame_tick && (st_q == SERVE || st_q == POINT))
      cnt_d = cnt_q + 6'd1;
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ball_reset <= 1'b0;
      ball_run   <= 1'b0;
      serve_dir  <= 1'b0;
      bounce_x   <= 1'b0;
      bounce_y   <= 1'b0;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      game_over  <= 1'b0;
      cnt_q      <= 6'd0;
    end else begin
      ball_reset <= ball_reset_d;
      ball_run   <= ball_run_d;
      serve_dir  <= serve_dir_d;
      bounce_x   <= bounce_x_d;
      bounce_y   <= bounce_y_d;
      score_l    <= score_l_d;
      score_r    <= score_r_d;
      game_over  <= game_over_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
